// File: rtl/bus_fabric_if.sv
// Bus bundle between the 65C02 side and the slave regions.
//   cpu_ad/cpu_we/cpu_do  : CPU address phase (from CPU)
//   cpu_di/cpu_rdy        : read data and RDY back to the CPU
//   s_cs/s_we/s_addr/s_wdata : registered data-phase strobes to slaves
//   s_rdata/s_ack         : per-region read data and ack (from slaves)
// modport slave  : the fabric's view.
// modport master : the surrounding system (CPU plus slaves) that drives
//                  the fabric's inputs and observes its outputs.
interface bus_fabric_if #(
    parameter int N_REG = 4,
    parameter int AW    = 16,
    parameter int DW    = 8
);
    logic [AW-1:0]       cpu_ad;
    logic                cpu_we;
    logic [DW-1:0]       cpu_do;
    logic [DW-1:0]       cpu_di;
    logic                cpu_rdy;
    logic [N_REG-1:0]    s_cs;
    logic                s_we;
    logic [AW-1:0]       s_addr;
    logic [DW-1:0]       s_wdata;
    logic [N_REG*DW-1:0] s_rdata;
    logic [N_REG-1:0]    s_ack;

    modport slave (
        input  cpu_ad, cpu_we, cpu_do, s_rdata, s_ack,
        output cpu_di, cpu_rdy, s_cs, s_we, s_addr, s_wdata
    );

    modport master (
        output cpu_ad, cpu_we, cpu_do, s_rdata, s_ack,
        input  cpu_di, cpu_rdy, s_cs, s_we, s_addr, s_wdata
    );
endinterface

// File: rtl/bus_fabric.sv
// Address decode, data-phase register, read mux and wait-state generator
// for a 65C02 bus with N_REG slave regions.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : bus_fabric_if.slave (CPU address phase, slave data phase)
//   err_clr   : clears bus_err
//   bus_err   : sticky error (miss or ack timeout)
//   err_addr  : address of the most recent error
module bus_fabric #(
    parameter int                    N_REG   = 4,
    parameter int                    AW      = 16,
    parameter int                    DW      = 8,
    parameter logic [N_REG*AW-1:0]   BASE    = {16'h8000, 16'h6000, 16'h5000, 16'h0000},
    parameter logic [N_REG*AW-1:0]   MASK    = {16'h8000, 16'hF000, 16'hF000, 16'hC000},
    parameter logic [N_REG*4-1:0]    WAIT    = {4'd0, 4'd15, 4'd2, 4'd0},
    parameter int                    TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    bus_fabric_if.slave   bus,
    input  logic          err_clr,
    output logic          bus_err,
    output logic [AW-1:0] err_addr
);
    localparam int         IW    = (N_REG > 1) ? $clog2(N_REG) : 1;
    localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, WAITC, ACKW} state_t;

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic [7:0]    tcnt, tcnt_nx;

    logic [IW-1:0] hit_idx, idx_q;
    logic          hit_miss, miss_q;
    logic          ph_q;        // 0 only straight after reset: suppresses the miss error
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic [3:0]    w;
    logic          ack;
    logic [DW-1:0] rd;
    logic          rdy, tmo, err_ev;

    // Descending scan so the lowest matching region wins.
    always_comb begin
        hit_idx  = '0;
        hit_miss = 1'b1;
        for (int i = N_REG - 1; i >= 0; i--) begin
            if ((bus.cpu_ad & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
                hit_idx  = IW'(i);
                hit_miss = 1'b0;
            end
        end
    end

    assign w   = WAIT[int'(idx_q)*4 +: 4];
    assign ack = bus.s_ack[idx_q];
    assign rd  = bus.s_rdata[int'(idx_q)*DW +: DW];

    // RUN always marks the first cycle of a data phase, because every
    // address latch (rdy=1) returns the FSM to RUN.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tcnt_nx  = tcnt;
        rdy      = 1'b1;
        tmo      = 1'b0;
        err_ev   = 1'b0;
        case (state)
            RUN: begin
                if (miss_q) begin
                    err_ev = ph_q;
                end else if (w == 4'd15) begin
                    if (!ack) begin
                        rdy      = 1'b0;
                        tcnt_nx  = TO_M1;
                        state_nx = ACKW;
                    end
                end else if (w != 4'd0) begin
                    rdy      = 1'b0;
                    cnt_nx   = w - 4'd1;
                    state_nx = WAITC;
                end
            end
            WAITC: begin
                if (cnt != 4'd0) begin
                    rdy    = 1'b0;
                    cnt_nx = cnt - 4'd1;
                end else begin
                    state_nx = RUN;
                end
            end
            ACKW: begin
                if (ack) begin
                    state_nx = RUN;
                end else if (tcnt == 8'd0) begin
                    tmo      = 1'b1;
                    err_ev   = 1'b1;
                    state_nx = RUN;
                end else begin
                    rdy     = 1'b0;
                    tcnt_nx = tcnt - 8'd1;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            cnt      <= '0;
            tcnt     <= '0;
            idx_q    <= '0;
            miss_q   <= 1'b1;
            ph_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            tcnt  <= tcnt_nx;
            if (rdy) begin
                idx_q   <= hit_idx;
                miss_q  <= hit_miss;
                ph_q    <= 1'b1;
                we_q    <= bus.cpu_we;
                addr_q  <= bus.cpu_ad;
                wdata_q <= bus.cpu_do;
            end
            // Set has priority over clear.
            if (err_ev) begin
                bus_err  <= 1'b1;
                err_addr <= addr_q;
            end else if (err_clr) begin
                bus_err <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.s_cs = '0;
        if (!miss_q) bus.s_cs[idx_q] = 1'b1;
    end

    assign bus.s_we    = we_q & ~miss_q & (state == RUN);
    assign bus.s_addr  = addr_q;
    assign bus.s_wdata = wdata_q;
    assign bus.cpu_rdy = rdy;
    assign bus.cpu_di  = (miss_q || tmo) ? {DW{1'b1}} : rd;
endmodule

// File: tb/tb_bus_fabric.sv
module tb_bus_fabric;
    logic        clk = 1'b0;
    logic        rst;
    logic        err_clr;
    logic        bus_err;
    logic [15:0] err_addr;
    int          n_chk = 0;
    int          n_err = 0;

    bus_fabric_if #(.N_REG(4), .AW(16), .DW(8)) bus ();

    bus_fabric dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .err_clr  (err_clr),
        .bus_err  (bus_err),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        err_clr     = 1'b0;
        bus.cpu_ad  = 16'h0000;
        bus.cpu_we  = 1'b0;
        bus.cpu_do  = 8'h00;
        bus.s_ack   = 4'b0000;
        bus.s_rdata = {8'hD3, 8'hC2, 8'hB1, 8'h5A};
        step();
        step();
        #1;
        // reset state
        chk("rst_cs",    32'(bus.s_cs), 32'h0);
        chk("rst_we",    32'(bus.s_we), 32'h0);
        chk("rst_rdy",   32'(bus.cpu_rdy), 32'h1);
        chk("rst_di",    32'(bus.cpu_di), 32'hFF);
        chk("rst_addr",  32'(bus.s_addr), 32'h0);
        chk("rst_wdata", 32'(bus.s_wdata), 32'h0);
        chk("rst_err",   32'(bus_err), 32'h0);
        chk("rst_eaddr", 32'(err_addr), 32'h0);

        // zero-wait back-to-back
        rst        = 1'b0;
        bus.cpu_ad = 16'h1234;
        step();
        chk("zw0_cs",  32'(bus.s_cs), 32'b0001);
        chk("zw0_di",  32'(bus.cpu_di), 32'h5A);
        chk("zw0_rdy", 32'(bus.cpu_rdy), 32'h1);
        chk("zw0_err", 32'(bus_err), 32'h0);
        bus.cpu_ad = 16'h8000;
        step();
        chk("zw1_cs",  32'(bus.s_cs), 32'b1000);
        chk("zw1_di",  32'(bus.cpu_di), 32'hD3);
        chk("zw1_rdy", 32'(bus.cpu_rdy), 32'h1);

        // fixed two-wait write
        bus.cpu_ad = 16'h5003;
        bus.cpu_we = 1'b1;
        bus.cpu_do = 8'h3C;
        step();
        chk("fw0_cs",    32'(bus.s_cs), 32'b0010);
        chk("fw0_we",    32'(bus.s_we), 32'h1);
        chk("fw0_wdata", 32'(bus.s_wdata), 32'h3C);
        chk("fw0_rdy",   32'(bus.cpu_rdy), 32'h0);
        chk("fw0_addr",  32'(bus.s_addr), 32'h5003);
        step();
        chk("fw1_cs",   32'(bus.s_cs), 32'b0010);
        chk("fw1_we",   32'(bus.s_we), 32'h0);
        chk("fw1_rdy",  32'(bus.cpu_rdy), 32'h0);
        chk("fw1_addr", 32'(bus.s_addr), 32'h5003);
        step();
        chk("fw2_cs",   32'(bus.s_cs), 32'b0010);
        chk("fw2_we",   32'(bus.s_we), 32'h0);
        chk("fw2_rdy",  32'(bus.cpu_rdy), 32'h1);
        chk("fw2_addr", 32'(bus.s_addr), 32'h5003);

        // ack handshake, ack arrives 4 cycles into the data phase
        bus.cpu_ad = 16'h6001;
        bus.cpu_we = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ack_stall%0d", i), 32'(bus.cpu_rdy), 32'h0);
            chk($sformatf("ack_cs%0d", i),    32'(bus.s_cs), 32'b0100);
            if (i < 3) step();
        end
        step();
        bus.s_ack = 4'b0100;
        #1;
        chk("ack_rdy", 32'(bus.cpu_rdy), 32'h1);
        chk("ack_di",  32'(bus.cpu_di), 32'hC2);
        chk("ack_err", 32'(bus_err), 32'h0);

        // timeout
        bus.cpu_ad = 16'h6000;
        step();
        bus.s_ack = 4'b0000;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to_stall%0d", i), 32'(bus.cpu_rdy), 32'h0);
            step();
        end
        chk("to_rdy", 32'(bus.cpu_rdy), 32'h1);
        chk("to_di",  32'(bus.cpu_di), 32'hFF);
        bus.cpu_ad = 16'h1234;
        step();
        chk("to_err",   32'(bus_err), 32'h1);
        chk("to_eaddr", 32'(err_addr), 32'h6000);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_err",   32'(bus_err), 32'h0);
        chk("clr_eaddr", 32'(err_addr), 32'h6000);

        // miss, with write suppressed; then set-vs-clear priority
        bus.cpu_ad = 16'h4800;
        bus.cpu_we = 1'b1;
        step();
        chk("miss_cs",  32'(bus.s_cs), 32'h0);
        chk("miss_we",  32'(bus.s_we), 32'h0);
        chk("miss_di",  32'(bus.cpu_di), 32'hFF);
        chk("miss_rdy", 32'(bus.cpu_rdy), 32'h1);
        bus.cpu_we = 1'b0;
        step();
        chk("miss_err",   32'(bus_err), 32'h1);
        chk("miss_eaddr", 32'(err_addr), 32'h4800);
        err_clr    = 1'b1;
        bus.cpu_ad = 16'h1234;
        step();
        err_clr = 1'b0;
        chk("prio_err", 32'(bus_err), 32'h1);
        chk("prio_cs",  32'(bus.s_cs), 32'b0001);
        err_clr    = 1'b1;
        step();
        err_clr = 1'b0;
        chk("prio_clr", 32'(bus_err), 32'h0);

        // reset in the second wait cycle of a 0x5000 write
        bus.cpu_ad = 16'h5000;
        bus.cpu_we = 1'b1;
        bus.cpu_do = 8'h77;
        step();
        chk("rw0_we",  32'(bus.s_we), 32'h1);
        chk("rw0_rdy", 32'(bus.cpu_rdy), 32'h0);
        step();
        chk("rw1_rdy", 32'(bus.cpu_rdy), 32'h0);
        rst = 1'b1;
        step();
        chk("rw2_cs",  32'(bus.s_cs), 32'h0);
        chk("rw2_we",  32'(bus.s_we), 32'h0);
        chk("rw2_rdy", 32'(bus.cpu_rdy), 32'h1);
        chk("rw2_err", 32'(bus_err), 32'h0);
        rst        = 1'b0;
        bus.cpu_ad = 16'h8001;
        bus.cpu_we = 1'b0;
        step();
        chk("rw3_cs",  32'(bus.s_cs), 32'b1000);
        chk("rw3_we",  32'(bus.s_we), 32'h0);
        chk("rw3_err", 32'(bus_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised successor to the fixed SoC address decode and data-in mux.
- Decodes the 65C02 address into N regions and registers the address phase, giving a one-cycle data phase for synchronous slaves.
- Muxes read data back to the CPU and drives RDY to insert wait states. Each region has either a fixed wait count or an ack handshake with timeout.
- Bus errors are reported through a sticky flag.

Parameters:
- N_REG, 4, number of slave regions.
- AW, 16, address width.
- DW, 8, data width.
- BASE, {16'h8000,16'h6000,16'h5000,16'h0000}, packed N_REG*AW region bases; region i occupies slice i.
- MASK, {16'h8000,16'hF000,16'hF000,16'hC000}, packed N_REG*AW region masks.
- WAIT, {4'd0,4'd15,4'd2,4'd0}, packed N_REG*4; 0-14 = fixed wait cycles, 15 = wait for s_ack.
- TIMEOUT, 16, maximum ack-wait cycles, 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- cpu_ad  in  AW  CPU address
- cpu_we  in  1  CPU write enable, active high
- cpu_do  in  DW  CPU write data
- cpu_di  out  DW  read data to CPU
- cpu_rdy  out  1  CPU RDY; low stalls the CPU
- s_cs  out  N_REG  one-hot slave select (data phase)
- s_we  out  1  write strobe, qualified by s_cs
- s_addr  out  AW  registered address
- s_wdata  out  DW  registered write data
- s_rdata  in  N_REG*DW  slave read data, region i = slice i
- s_ack  in  N_REG  per-region ready for WAIT=15 regions
- err_clr  in  1  clears bus_err
- bus_err  out  1  sticky error flag
- err_addr  out  AW  address of the most recent error

Behaviour:
- Decode (combinational on cpu_ad): region i hits if (cpu_ad & MASK_i) == BASE_i. The lowest index wins on overlap. No hit sets miss.
- Address register: when cpu_rdy=1, on each posedge latch cpu_ad->s_addr, cpu_we->we_q, cpu_do->s_wdata, and hit index plus miss->sel_q. When cpu_rdy=0, hold all of these (the CPU holds its bus while stalled).
- Data phase begins the cycle after the address is latched; s_cs[sel_q]=1 for the whole data phase, including wait cycles.
- s_we=we_q only in the first data-phase cycle, so slaves with side effects see a single strobe.
- cpu_di = s_rdata[sel_q] during the data phase; 8'hFF on miss or timeout.
- FSM states: RUN, WAITC, ACKW.
  - RUN: new data phase with W=WAIT[sel_q].
    - W=0: cpu_rdy=1 and stay in RUN.
    - W in 1..14: cpu_rdy=0, load cnt=W-1, go to WAITC.
    - W=15 and s_ack[sel_q]=1 this cycle: cpu_rdy=1 and stay in RUN.
    - W=15 otherwise: cpu_rdy=0, load tcnt=TIMEOUT-1, go to ACKW.
  - WAITC: cpu_rdy=0 while cnt!=0, decrementing each cycle. When cnt==0, cpu_rdy=1 and go to RUN. Total stall = W cycles.
  - ACKW: s_ack[sel_q]=1 gives cpu_rdy=1 with slave data, then RUN. tcnt==0 without ack is a timeout: cpu_rdy=1, cpu_di=8'hFF, error, then RUN.
- Miss: no s_cs, s_we suppressed, cpu_rdy=1, cpu_di=8'hFF, error.
- Error event: bus_err<=1 and err_addr<=s_addr. If err_clr=1 in the same cycle as an error event, set wins. err_clr alone clears bus_err; err_addr is retained.
- Reset values: s_cs=0, s_we=0, cpu_rdy=1, cpu_di=8'hFF, s_addr=0, s_wdata=0, bus_err=0, err_addr=0, FSM=RUN, sel_q=miss with error suppressed.
  - Reset mid-wait aborts the access: no further s_we, s_cs=0 the next cycle, and no error is logged.
- Back-to-back zero-wait accesses sustain one access per cycle with no bubble.

Test Plan:
- Zero-wait read: cpu_ad=0x1234, s_rdata[0]=0x5A -> next cycle s_cs=4'b0001, cpu_di=0x5A, cpu_rdy stays 1. Back-to-back 0x1234 then 0x8000 -> s_cs 0001 then 1000 on consecutive cycles.
- Fixed wait write: cpu_ad=0x5003, cpu_we=1, cpu_do=0x3C -> s_cs=0010 for 3 cycles, s_we=1 only in the first with s_wdata=0x3C, cpu_rdy=0 for exactly 2 cycles, s_addr held at 0x5003.
- Ack handshake: read 0x6001, s_ack[2] asserted 4 cycles into the data phase -> cpu_rdy=0 for 4 cycles, then 1 with cpu_di=s_rdata[2]; bus_err stays 0.
- Timeout: read 0x6000, s_ack never asserted -> cpu_rdy=0 for 16 cycles, then 1 with cpu_di=0xFF, bus_err=1, err_addr=0x6000. err_clr pulsed -> bus_err=0, err_addr still 0x6000.
- Miss and priority: read 0x4800 -> s_cs=0000, cpu_di=0xFF, bus_err=1. err_clr=1 on the same cycle as a new miss -> bus_err remains 1.
- Reset mid-wait: rst asserted in the 2nd wait cycle of a 0x5000 access -> next cycle s_cs=0, cpu_rdy=1, FSM=RUN, bus_err=0, no second s_we.
